// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the encrypt datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_W  = 128;

  typedef logic [AES_W-1:0] aes_state_t;
  typedef logic [3:0]       aes_round_t;

  typedef struct packed {
    aes_state_t state;
    aes_round_t round;
    logic       last;
  } aes_ark_word_t;

  // Round counter advance: wraps to 0 after the final round.
  function automatic aes_round_t aes_next_round(input aes_round_t r, input aes_round_t nr);
    return (r == nr) ? '0 : r + 4'd1;
  endfunction

endpackage

// File: rtl/aes_add_round_key_stage_if.sv
// State, round-key and output streams of the AddRoundKey stage.
interface aes_add_round_key_stage_if;
  import aes_pkg::*;

  logic       s_valid;
  logic       s_ready;
  aes_state_t s_state;
  logic       s_first;
  logic       k_valid;
  logic       k_ready;
  aes_state_t k_key;
  logic       m_valid;
  logic       m_ready;
  aes_state_t m_state;
  aes_round_t m_round;
  logic       m_last;

  // Stage side.
  modport slave (
    input  s_valid, s_state, s_first, k_valid, k_key, m_ready,
    output s_ready, k_ready, m_valid, m_state, m_round, m_last
  );

  // Producer/consumer side.
  modport master (
    output s_valid, s_state, s_first, k_valid, k_key, m_ready,
    input  s_ready, k_ready, m_valid, m_state, m_round, m_last
  );

endinterface

// File: rtl/aes_skid_fifo2.sv
// Two-entry valid/ready queue carrying {state, round, last}; head drives the output.
module aes_skid_fifo2
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  aes_ark_word_t in_word,
  output logic          out_valid,
  input  logic          out_ready,
  output aes_ark_word_t out_word
);

  aes_ark_word_t mem_q [2];
  aes_ark_word_t mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          full;
  logic          push;
  logic          pop;

  assign full      = (count_q == 2'd2);
  assign in_ready  = ~full;
  assign out_valid = (count_q != 2'd0);
  assign out_word  = mem_q[rd_ptr_q];

  // A full queue refuses a push even when the head pops in the same cycle.
  assign push = in_valid & ~full;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/aes_add_round_key_stage.sv
// Registered AddRoundKey stage: joins state and key streams, XORs, tags round, queues.
// Optional macro AES_ARK_STATS_EN enables the completed-block counter on blk_count.
module aes_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned W  = AES_W
) (
  input  logic                        clk,
  input  logic                        rst,
  aes_add_round_key_stage_if.slave    bus,
  output logic                        err,
  output logic [31:0]                 blk_count
);

  localparam aes_round_t NR_R = aes_round_t'(NR);

  aes_round_t    round_q, round_d;
  logic          err_q, err_d;
  aes_round_t    tag;
  logic          fire;
  logic          join_valid;
  logic          fifo_in_ready;
  logic [W-1:0]  xor_state;
  aes_ark_word_t in_word;
  aes_ark_word_t out_word;

  assign join_valid  = bus.s_valid & bus.k_valid;
  assign fire        = join_valid & fifo_in_ready;
  assign xor_state   = bus.s_state ^ bus.k_key;
  assign bus.s_ready = fifo_in_ready;
  assign bus.k_ready = fifo_in_ready;

  // s_first forces round 0 so a stray first marker resynchronises the counter.
  always_comb begin
    tag     = bus.s_first ? '0 : round_q;
    round_d = round_q;
    err_d   = err_q;
    if (fire) begin
      round_d = aes_next_round(tag, NR_R);
      if (bus.s_first && (round_q != '0)) begin
        err_d = 1'b1;
      end
      if (!bus.s_first && (round_q == '0)) begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_word       = '0;
    in_word.state = xor_state;
    in_word.round = tag;
    in_word.last  = (tag == NR_R);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= '0;
      err_q   <= 1'b0;
    end else begin
      round_q <= round_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  aes_skid_fifo2 u_queue (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (join_valid),
    .in_ready  (fifo_in_ready),
    .in_word   (in_word),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .out_word  (out_word)
  );

  assign bus.m_state = out_word.state;
  assign bus.m_round = out_word.round;
  assign bus.m_last  = out_word.last;

`ifdef AES_ARK_STATS_EN
  logic [31:0] blk_count_q, blk_count_d;

  // A last-tagged word can never carry s_first, so error fires are excluded.
  always_comb begin
    blk_count_d = blk_count_q;
    if (fire && in_word.last) begin
      blk_count_d = blk_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q <= '0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = '0;
`endif

endmodule

// File: tb/tb_aes_add_round_key_stage.sv
// Self-checking bench for aes_add_round_key_stage against a queue-based reference model.
module tb_aes_add_round_key_stage;

  localparam int NR = 10;

  typedef struct {
    logic [127:0] state;
    int           round;
    bit           last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        err;
  logic [31:0] blk_count;

  aes_add_round_key_stage_if bus_if ();

  aes_add_round_key_stage #(.NR(10), .W(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .err       (err),
    .blk_count (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        mq[$];
  int          mdl_round;
  bit          mdl_err;
  logic [31:0] mdl_blk;
  int          checks;
  int          errors;

  // Reference: a word is accepted when both streams are valid and fewer than two are queued.
  task automatic cycle();
    bit   fire;
    bit   pop;
    exp_t w;
    fire = 0;
    pop  = 0;
    w    = '{state: '0, round: 0, last: 0};
    if (!rst) begin
      fire = bus_if.s_valid && bus_if.k_valid && (mq.size() < 2);
      pop  = (mq.size() > 0) && bus_if.m_ready;
    end
    if (fire) begin
      w.state = bus_if.s_state ^ bus_if.k_key;
      if (bus_if.s_first) begin
        if (mdl_round != 0) mdl_err = 1;
        w.round = 0;
      end else begin
        if (mdl_round == 0) mdl_err = 1;
        w.round = mdl_round;
      end
      w.last    = (w.round == NR);
      mdl_round = (w.round + 1) % (NR + 1);
`ifdef AES_ARK_STATS_EN
      if (w.last) mdl_blk = mdl_blk + 32'd1;
`endif
    end
    if (pop) void'(mq.pop_front());
    if (fire) mq.push_back(w);
    if (rst) begin
      mq.delete();
      mdl_round = 0;
      mdl_err   = 0;
      mdl_blk   = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus_if.s_valid = 1'b0;
    bus_if.k_valid = 1'b0;
    bus_if.s_first = 1'b0;
  endtask

  task automatic set_word(input bit first);
    bus_if.s_valid = 1'b1;
    bus_if.k_valid = 1'b1;
    bus_if.s_first = first;
    bus_if.s_state = {$urandom, $urandom, $urandom, $urandom};
    bus_if.k_key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    bus_if.m_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    checks++;
    if ({bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b st=%h r=%0d l=%b, expected all zero",
               bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last);
    end
    checks++;
    if ({bus_if.s_ready, bus_if.k_ready, err, blk_count} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: got s_rdy=%b k_rdy=%b err=%b blk=%0d, expected 1 1 0 0",
               bus_if.s_ready, bus_if.k_ready, err, blk_count);
    end
  endtask

  task automatic test_fips();
    logic [127:0] exp_st;
    exp_st = 128'h00102030405060708090a0b0c0d0e0f0;
    do_reset();
    bus_if.m_ready = 1'b1;
    bus_if.s_valid = 1'b1;
    bus_if.k_valid = 1'b1;
    bus_if.s_first = 1'b1;
    bus_if.s_state = 128'h00112233445566778899aabbccddeeff;
    bus_if.k_key   = 128'h000102030405060708090a0b0c0d0e0f;
    cycle();
    set_idle();
    checks++;
    if ({bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last} !== {1'b1, exp_st, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL fips_round0: got v=%b st=%h r=%0d l=%b, expected v=1 st=%h r=0 l=0",
               bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last, exp_st);
    end
    cycle();
    checks++;
    if (bus_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_drain: got m_valid=%b, expected 0", bus_if.m_valid);
    end
  endtask

  task automatic test_full_block();
    do_reset();
    bus_if.m_ready = 1'b1;
    for (int i = 0; i <= NR; i++) begin
      set_word(i == 0);
      cycle();
      checks++;
      if (mq.size() == 0 ||
          {bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last} !==
          {1'b1, mq[0].state, 4'(i), (i == NR)}) begin
        errors++;
        $display("FAIL full_block_word%0d: got v=%b st=%h r=%0d l=%b, expected r=%0d l=%b",
                 i, bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last, i, (i == NR));
      end
    end
    set_idle();
    cycle();
    checks++;
`ifdef AES_ARK_STATS_EN
    if (blk_count !== 32'd1) begin
`else
    if (blk_count !== 32'd0) begin
`endif
      errors++;
      $display("FAIL full_block_count: got blk_count=%0d", blk_count);
    end
    set_word(1'b1);
    cycle();
    set_idle();
    checks++;
    if ({bus_if.m_round, err} !== {4'd0, 1'b0}) begin
      errors++;
      $display("FAIL full_block_wrap: got r=%0d err=%b, expected r=0 err=0", bus_if.m_round, err);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    do_reset();
    bus_if.m_ready = 1'b0;
    held = '0;
    for (int k = 1; k <= 5; k++) begin
      set_word(mdl_round == 0);
      cycle();
      if (k == 1) held = bus_if.m_state;
      checks++;
      if ((k >= 2 && {bus_if.s_ready, bus_if.k_ready} !== 2'b00) ||
          bus_if.m_valid !== 1'b1 || bus_if.m_state !== held || bus_if.m_state !== mq[0].state) begin
        errors++;
        $display("FAIL backpressure_stall%0d: got s_rdy=%b k_rdy=%b v=%b st=%h, expected held %h",
                 k, bus_if.s_ready, bus_if.k_ready, bus_if.m_valid, bus_if.m_state, held);
      end
    end
    set_idle();
    bus_if.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mq.size() == 0 ? (bus_if.m_valid !== 1'b0) :
          ({bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last} !==
           {1'b1, mq[0].state, 4'(mq[0].round), mq[0].last})) begin
        errors++;
        $display("FAIL backpressure_drain%0d: got v=%b st=%h r=%0d, expected %0d queued",
                 k, bus_if.m_valid, bus_if.m_state, bus_if.m_round, mq.size());
      end
      cycle();
    end
  endtask

  task automatic test_skew();
    logic [127:0] sv;
    logic [127:0] kv;
    do_reset();
    bus_if.m_ready = 1'b1;
    sv = {$urandom, $urandom, $urandom, $urandom};
    kv = {$urandom, $urandom, $urandom, $urandom};
    bus_if.s_valid = 1'b1;
    bus_if.s_first = 1'b1;
    bus_if.s_state = sv;
    bus_if.k_valid = 1'b0;
    bus_if.k_key   = kv;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({bus_if.m_valid, bus_if.s_ready, bus_if.k_ready} !== 3'b011) begin
        errors++;
        $display("FAIL skew_wait%0d: got v=%b s_rdy=%b k_rdy=%b, expected 0 1 1",
                 k, bus_if.m_valid, bus_if.s_ready, bus_if.k_ready);
      end
    end
    bus_if.k_valid = 1'b1;
    cycle();
    set_idle();
    checks++;
    if ({bus_if.m_valid, bus_if.m_state, bus_if.m_round} !== {1'b1, sv ^ kv, 4'd0}) begin
      errors++;
      $display("FAIL skew_join: got v=%b st=%h r=%0d, expected st=%h r=0",
               bus_if.m_valid, bus_if.m_state, bus_if.m_round, sv ^ kv);
    end
    cycle();
  endtask

  task automatic test_protocol_err();
    do_reset();
    bus_if.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_word(i == 0);
      cycle();
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL proto_clean: got err=%b, expected 0", err);
    end
    set_word(1'b1);
    cycle();
    checks++;
    if ({err, bus_if.m_round} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL proto_first_at4: got err=%b r=%0d, expected err=1 r=0", err, bus_if.m_round);
    end
    set_word(1'b0);
    cycle();
    set_idle();
    checks++;
    if ({err, bus_if.m_round} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL proto_resync: got err=%b r=%0d, expected err=1 r=1", err, bus_if.m_round);
    end
    for (int k = 0; k < 3; k++) cycle();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got err=%b, expected 1", err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus_if.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_word(1'b0);
      cycle();
    end
    set_idle();
    cycle();
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_word(1'b0);
      cycle();
    end
    set_idle();
    checks++;
    if ({err, bus_if.s_ready, bus_if.m_valid} !== 3'b101 || mdl_round != 6) begin
      errors++;
      $display("FAIL midrst_setup: got err=%b s_rdy=%b v=%b model_round=%0d, expected 1 0 1 6",
               err, bus_if.s_ready, bus_if.m_valid, mdl_round);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({bus_if.m_valid, bus_if.s_ready, bus_if.k_ready, err, bus_if.m_state, bus_if.m_round, blk_count} !==
        {1'b0, 1'b1, 1'b1, 1'b0, 128'd0, 4'd0, 32'd0}) begin
      errors++;
      $display("FAIL midrst_cleared: got v=%b s_rdy=%b err=%b st=%h r=%0d blk=%0d, expected 0 1 0 0 0 0",
               bus_if.m_valid, bus_if.s_ready, err, bus_if.m_state, bus_if.m_round, blk_count);
    end
    bus_if.m_ready = 1'b1;
    set_word(1'b1);
    cycle();
    set_idle();
    checks++;
    if ({bus_if.m_valid, bus_if.m_round, err} !== {1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_restart: got v=%b r=%0d err=%b, expected 1 0 0",
               bus_if.m_valid, bus_if.m_round, err);
    end
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      set_word(mdl_round == 0);
      bus_if.s_valid = ($urandom_range(0, 3) != 0);
      bus_if.k_valid = ($urandom_range(0, 3) != 0);
      bus_if.m_ready = ($urandom_range(0, 2) != 0);
      cycle();
      checks++;
      if ({bus_if.s_ready, bus_if.k_ready} !== {2{mq.size() < 2}} ||
          (mq.size() == 0 ? (bus_if.m_valid !== 1'b0) :
           ({bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last} !==
            {1'b1, mq[0].state, 4'(mq[0].round), mq[0].last}))) begin
        errors++;
        $display("FAIL random_cycle%0d: got v=%b st=%h r=%0d l=%b s_rdy=%b, expected %0d queued",
                 k, bus_if.m_valid, bus_if.m_state, bus_if.m_round, bus_if.m_last,
                 bus_if.s_ready, mq.size());
      end
    end
    set_idle();
    checks++;
    if ({err, blk_count} !== {mdl_err, mdl_blk}) begin
      errors++;
      $display("FAIL random_status: got err=%b blk=%0d, expected err=%b blk=%0d",
               err, blk_count, mdl_err, mdl_blk);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mdl_round = 0;
    mdl_err   = 0;
    mdl_blk   = '0;
    rst       = 1'b1;
    bus_if.s_valid = 1'b0;
    bus_if.k_valid = 1'b0;
    bus_if.s_first = 1'b0;
    bus_if.s_state = '0;
    bus_if.k_key   = '0;
    bus_if.m_ready = 1'b0;
    test_reset();
    test_fips();
    test_full_block();
    test_backpressure();
    test_skew();
    test_protocol_err();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
